cmp_debounce_monitor: RTL
=========================

CMP_DEBOUNCE_MONITOR -- requirements
Module: cmp_debounce_monitor

Interface
REQ-001 Parameter DEBOUNCE, default 3, range 1..15: consecutive agreeing samples required to change state.
REQ-002 Parameter CNT_W, default 8: width of each statistics counter.
REQ-003 Port clk  input  1  single clock; all state updates on rising edge.
REQ-004 Port rst  input  1  synchronous, active-high reset.
REQ-005 Port in_valid  input  1  gt/eq/lt carry a sample this cycle.
REQ-006 Ports gt, eq, lt  input  1 each  magnitude-comparator flags (A>B, A==B, A<B).
REQ-007 Port stats_clr  input  1  single-cycle clear of counters and error flag.
REQ-008 Port state  output  2  debounced relation: 0 UNKNOWN, 1 BELOW, 2 EQUAL, 3 ABOVE.
REQ-009 Port change  output  1  one-cycle pulse, high in the cycle state takes a new value.
REQ-010 Ports gt_cnt, eq_cnt, lt_cnt  output  CNT_W each  accepted legal samples per class.
REQ-011 Port err  output  1  sticky: an illegal (non-one-hot) sample was seen.

Function
REQ-012 Sample accepted iff in_valid=1; in_valid=0 cycles are ignored and do not break a run.
REQ-013 Legal sample = exactly one of gt/eq/lt high; class map: lt->BELOW, eq->EQUAL, gt->ABOVE.
REQ-014 Internal registers: candidate class (2 bits), run counter (4 bits).
REQ-015 Legal sample with class == state: run cleared to 0, candidate unchanged, state held.
REQ-016 Legal sample with class != state and class == candidate: run incremented.
REQ-017 Legal sample with class != state and class != candidate: candidate <= class, run <= 1.
REQ-018 When run reaches DEBOUNCE on the current sample, state <= candidate on the next edge, run <= 0, change=1 for exactly that cycle.
REQ-019 DEBOUNCE=1: each legal sample whose class differs from state switches state on the next edge.
REQ-020 UNKNOWN is left only by REQ-018; it is never re-entered except through reset.
REQ-021 Illegal sample (zero flags or two or more flags): err <= 1, run <= 0, state and candidate held, no counter increments.
REQ-022 Each legal accepted sample increments its class counter by 1; counters saturate at 2^CNT_W-1 and never wrap.
REQ-023 stats_clr=1: all counters and err go to 0 next edge; clear wins over a same-cycle increment or error; FSM still processes the sample.
REQ-024 All outputs registered; latency from accepted sample to state/counter/err update is 1 cycle.

Reset
REQ-025 rst=1 at an edge: state=UNKNOWN, candidate=UNKNOWN, run=0, change=0, counters=0, err=0.
REQ-026 Reset mid-run discards the partial run; rst takes priority over every other input.

Configuration
REQ-027 Macro CMP_MON_STATS_EN defined: gt_cnt/eq_cnt/lt_cnt implemented per REQ-022/023.
REQ-028 Macro CMP_MON_STATS_EN undefined: no counter registers; the three count ports are driven constant 0; err and stats_clr clearing of err are unaffected.

Structure
REQ-029 Shared package cmp_mon_pkg holds the 2-bit state enum (UNKNOWN/BELOW/EQUAL/ABOVE) and the flag-to-class decode function.
REQ-030 One sub-module, sat_counter (parameter width, inc, clr), instantiated three times for the statistics counters.

Verification (DEBOUNCE=3, CNT_W=8)
REQ-031 Reset, then 3 valid samples gt=1 -> state=ABOVE one cycle after the 3rd sample, change pulses once, gt_cnt=3.
REQ-032 From ABOVE: lt, lt, in_valid=0 for 2 cycles, lt -> state=BELOW after the 3rd lt; sequence lt, lt, eq, lt instead -> state stays ABOVE.
REQ-033 Sample gt=1 and eq=1 together -> err=1, counters unchanged, run cleared; then stats_clr -> err=0, all counters 0.
REQ-034 260 consecutive valid eq samples -> eq_cnt saturates at 255; state=EQUAL from the 3rd sample onward.
REQ-035 Two eq samples, then rst=1, then one eq -> state remains UNKNOWN (run restarted at 1).
REQ-036 Build without CMP_MON_STATS_EN, repeat REQ-031 -> state/change identical, all count ports read 0.

Source files
------------

// File: rtl/cmp_mon_pkg.sv
// Shared types and flag decode for the comparator debounce monitor.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
//
// Holds the debounced-relation enum and the decode from raw magnitude-comparator
// flags to a relation class. An illegal flag pattern (not one-hot) decodes to
// UNKNOWN, which no legal sample can ever produce.
package cmp_mon_pkg;

   typedef enum logic [1:0] {
      UNKNOWN = 2'd0,
      BELOW   = 2'd1,
      EQUAL   = 2'd2,
      ABOVE   = 2'd3
   } cmp_state_e;

   // Width of the agreeing-sample run counter; holds DEBOUNCE up to 15.
   localparam int RUN_W = 4;

   function automatic cmp_state_e flags_to_class(input logic gt,
                                                 input logic eq,
                                                 input logic lt);
      cmp_state_e cls;
      case ({gt, eq, lt})
         3'b100:  cls = ABOVE;
         3'b010:  cls = EQUAL;
         3'b001:  cls = BELOW;
         default: cls = UNKNOWN;
      endcase
      return cls;
   endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter used for the per-class sample statistics.
// Latency: 1 cycle from inc/clr to count.
// Backpressure: none; inc is ignored once the counter sits at all-ones.
//
// Ports: clk, rst (sync, active-high), inc (count one event), clr (zero the
// counter, wins over inc), count (current value, registered).
// Only built when CMP_MON_STATS_EN is defined, since that is the only
// configuration in which the monitor instantiates it.
`ifdef CMP_MON_STATS_EN
module sat_counter #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             inc,
   input  logic             clr,
   output logic [WIDTH-1:0] count
);

   logic [WIDTH-1:0] cnt_q;

   always_ff @(posedge clk) begin
      if (rst || clr) begin
         cnt_q <= '0;
      end else if (inc && (cnt_q != {WIDTH{1'b1}})) begin
         cnt_q <= cnt_q + {{(WIDTH-1){1'b0}}, 1'b1};
      end
   end

   assign count = cnt_q;

endmodule
`endif

// File: rtl/cmp_debounce_monitor.sv
// Debounces magnitude-comparator flags into a stable relation, with statistics.
// Latency: 1 cycle from an accepted sample to state/change/err/count update.
// Backpressure: none; in_valid=0 cycles are skipped without breaking a run.
//
// Ports:
//   clk, rst              single clock, synchronous active-high reset
//   in_valid, gt, eq, lt  sample strobe and comparator flags (A>B, A==B, A<B)
//   stats_clr             one-cycle clear of the counters and the err flag
//   state                 debounced relation (0 UNKNOWN, 1 BELOW, 2 EQUAL, 3 ABOVE)
//   change                one-cycle pulse in the cycle state takes a new value
//   gt_cnt/eq_cnt/lt_cnt  saturating counts of accepted legal samples per class
//   err                   sticky flag: a non-one-hot sample was accepted
// Build option: define CMP_MON_STATS_EN to implement the counters; otherwise
// the three count ports are tied to zero and no counter registers exist.
module cmp_debounce_monitor
   import cmp_mon_pkg::*;
#(
   parameter int DEBOUNCE = 3,   // 1..15 consecutive agreeing samples
   parameter int CNT_W    = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   input  logic             gt,
   input  logic             eq,
   input  logic             lt,
   input  logic             stats_clr,
   output logic [1:0]       state,
   output logic             change,
   output logic [CNT_W-1:0] gt_cnt,
   output logic [CNT_W-1:0] eq_cnt,
   output logic [CNT_W-1:0] lt_cnt,
   output logic             err
);

   localparam logic [RUN_W-1:0] DEB_RUN = RUN_W'(DEBOUNCE);

   cmp_state_e       state_q;
   cmp_state_e       cand_q, cand_d;
   logic [RUN_W-1:0] run_q, run_d;
   logic             switch_d;
   logic             change_q;
   logic             err_q;

   cmp_state_e       cls;
   logic             legal;

   assign cls   = flags_to_class(gt, eq, lt);
   assign legal = (cls != UNKNOWN);

   // Next candidate/run and whether this sample completes a run. A new
   // candidate starts its run at 1 so that DEBOUNCE=1 switches immediately.
   always_comb begin
      cand_d   = cand_q;
      run_d    = run_q;
      switch_d = 1'b0;
      if (in_valid) begin
         if (!legal || (cls == state_q)) begin
            run_d = '0;
         end else begin
            if (cls == cand_q) begin
               run_d = run_q + {{(RUN_W-1){1'b0}}, 1'b1};
            end else begin
               cand_d = cls;
               run_d  = {{(RUN_W-1){1'b0}}, 1'b1};
            end
            if (run_d == DEB_RUN) begin
               switch_d = 1'b1;
               run_d    = '0;
            end
         end
      end
   end

   // Debounce FSM plus the sticky error flag. cand_d always equals the
   // class that completed the run, so it is what state takes on a switch.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= UNKNOWN;
         cand_q   <= UNKNOWN;
         run_q    <= '0;
         change_q <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         cand_q   <= cand_d;
         run_q    <= run_d;
         change_q <= switch_d;
         if (switch_d) begin
            state_q <= cand_d;
         end
         if (stats_clr) begin
            err_q <= 1'b0;
         end else if (in_valid && !legal) begin
            err_q <= 1'b1;
         end
      end
   end

   assign state  = state_q;
   assign change = change_q;
   assign err    = err_q;

`ifdef CMP_MON_STATS_EN
   // cls is UNKNOWN for illegal samples, so no extra legality term is needed.
   logic inc_gt, inc_eq, inc_lt;

   assign inc_gt = in_valid && (cls == ABOVE);
   assign inc_eq = in_valid && (cls == EQUAL);
   assign inc_lt = in_valid && (cls == BELOW);

   sat_counter #(.WIDTH(CNT_W)) u_gt_cnt (
      .clk   (clk),
      .rst   (rst),
      .inc   (inc_gt),
      .clr   (stats_clr),
      .count (gt_cnt)
   );

   sat_counter #(.WIDTH(CNT_W)) u_eq_cnt (
      .clk   (clk),
      .rst   (rst),
      .inc   (inc_eq),
      .clr   (stats_clr),
      .count (eq_cnt)
   );

   sat_counter #(.WIDTH(CNT_W)) u_lt_cnt (
      .clk   (clk),
      .rst   (rst),
      .inc   (inc_lt),
      .clr   (stats_clr),
      .count (lt_cnt)
   );
`else
   assign gt_cnt = '0;
   assign eq_cnt = '0;
   assign lt_cnt = '0;
`endif

endmodule
